// File: rtl/bnn_pixel_feeder.sv
// bnn_pixel_feeder: binarizes a raster pixel stream into two ping-pong frame banks
// and serves each complete frame one bit per cycle over the rcv_req/rcv_ack port.
module bnn_pixel_feeder #(
  parameter int PIXEL_NUM = 784,
  parameter int PIX_W     = 8,
  parameter int THRESHOLD = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  input  logic             rcv_req,
  output logic             rcv_ack,
  output logic             inputs,
  output logic             frame_drop,
  output logic             busy
);

  localparam int               IDX_W    = $clog2(PIXEL_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND} send_state_t;

  send_state_t          state, state_nxt;
  logic [PIXEL_NUM-1:0] bank [2];
  logic [1:0]           full, full_nxt;
  logic                 wr_bank, rd_bank, rd_bank_nxt;
  logic [IDX_W-1:0]     wr_idx, wr_idx_nxt, wr_addr;
  logic [IDX_W-1:0]     rd_idx, rd_idx_nxt;
  logic                 xfer, resync, fill, pix_bit, rel_bank;
  logic                 rcv_ack_nxt, inputs_nxt;

  // ---------------------------------------------------------------- load side
  assign pix_ready = !full[wr_bank];
  assign xfer      = pix_valid && pix_ready;
  // An sof in mid-frame restarts the frame: the partial bank contents are simply
  // overwritten from index 0.
  assign resync    = xfer && pix_sof && (wr_idx != '0);
  assign fill      = xfer && !resync && (wr_idx == LAST_IDX);
  assign wr_addr   = resync ? '0 : wr_idx;
  assign pix_bit   = (pix_data >= PIX_W'(THRESHOLD));

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    wr_idx_nxt = wr_idx;
    if (resync)
      wr_idx_nxt = IDX_W'(1);
    else if (fill)
      wr_idx_nxt = '0;
    else if (xfer)
      wr_idx_nxt = wr_idx + IDX_W'(1);
  end

  // NOTE: frame storage has no reset; full[] alone says whether a bank holds data.
  always_ff @(posedge clk) begin
    if (xfer)
      bank[wr_bank][wr_addr] <= pix_bit;
  end

  // ---------------------------------------------------------------- send side
  // IDLE also sees a fill landing this cycle, so GAP starts right after the last
  // pixel and the first ack appears two cycles after it.
  always_comb begin
    state_nxt   = state;
    rd_idx_nxt  = rd_idx;
    rd_bank_nxt = rd_bank;
    rcv_ack_nxt = 1'b0;
    inputs_nxt  = 1'b0;
    rel_bank    = 1'b0;
    case (state)
      S_IDLE: begin
        if ((full[rd_bank] || (fill && (wr_bank == rd_bank))) && rcv_req)
          state_nxt = S_GAP;
      end
      S_GAP: begin
        state_nxt   = S_SEND;
        rd_idx_nxt  = '0;
        rcv_ack_nxt = 1'b1;
        inputs_nxt  = bank[rd_bank][0];
      end
      S_SEND: begin
        if (rd_idx == LAST_IDX) begin
          state_nxt   = S_IDLE;
          rel_bank    = 1'b1;
          rd_bank_nxt = !rd_bank;
        end else begin
          rd_idx_nxt  = rd_idx + IDX_W'(1);
          rcv_ack_nxt = 1'b1;
          inputs_nxt  = bank[rd_bank][rd_idx_nxt];
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Release is applied before fill, so a fill into the bank being released wins.
  always_comb begin
    full_nxt = full;
    if (rel_bank)
      full_nxt[rd_bank] = 1'b0;
    if (fill)
      full_nxt[wr_bank] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      rcv_ack    <= 1'b0;
      inputs     <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      full       <= full_nxt;
      if (fill)
        wr_bank  <= !wr_bank;
      rd_bank    <= rd_bank_nxt;
      wr_idx     <= wr_idx_nxt;
      rd_idx     <= rd_idx_nxt;
      rcv_ack    <= rcv_ack_nxt;
      inputs     <= inputs_nxt;
      frame_drop <= resync;
    end
  end

  assign busy = (|full) || (state != S_IDLE);

endmodule
